// File: rtl/irq_pkg.sv
// Shared constants and helpers for the interrupt pending latch.
// Level-sensitive lines are available when IRQ_LEVEL_MODE_EN is defined.
package irq_pkg;

    localparam int N_IRQ = 8;
    localparam int IDX_W = 3;

    // One-hot decode of an index; indexes beyond the request count decode to zero.
    function automatic logic [N_IRQ-1:0] onehot_dec(input logic [IDX_W-1:0] idx);
        logic [N_IRQ-1:0] vec;
        vec = {N_IRQ{1'b0}};
        if ({1'b0, idx} < (IDX_W + 1)'(N_IRQ)) begin
            vec[idx] = 1'b1;
        end else begin
            vec = {N_IRQ{1'b0}};
        end
        return vec;
    endfunction

endpackage

// File: rtl/irq_edge_det.sv
// N-bit rising-edge detector. Reset loads the current input so that lines
// already high during reset never produce an edge afterwards.
module irq_edge_det #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] irq,
    output logic [N-1:0] rise
);

    logic [N-1:0] irq_prev_r;

    // Previous-cycle copy of the request lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_prev_r <= irq;
        end else begin
            irq_prev_r <= irq;
        end
    end

    assign rise = irq & ~irq_prev_r;

endmodule

// File: rtl/irq_pending_latch.sv
// Sticky pending register with software mask and ack/index retirement,
// feeding the 8:3 priority encoder. Define IRQ_LEVEL_MODE_EN to add level_sel.
module irq_pending_latch
    import irq_pkg::*;
#(
    parameter int N    = N_IRQ,
    parameter int IDXW = IDX_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    irq,
`ifdef IRQ_LEVEL_MODE_EN
    input  logic [N-1:0]    level_sel,
`endif
    input  logic            mask_wr,
    input  logic [N-1:0]    mask_in,
    output logic [N-1:0]    mask,
    output logic [N-1:0]    pend,
    output logic            irq_valid,
    input  logic            ack,
    input  logic [IDXW-1:0] ack_idx,
    output logic [N-1:0]    overflow
);

    logic [N-1:0]     pending_r;
    logic [N-1:0]     mask_r;
    logic [N-1:0]     ovf_r;
    logic [N-1:0]     rise_s;
    logic [N-1:0]     lvl_s;
    logic [N_IRQ-1:0] dec_s;
    logic [N-1:0]     clr_s;
    logic [N-1:0]     ovf_set_s;
    logic [N-1:0]     pending_nxt_s;
    logic [N-1:0]     ovf_nxt_s;

    irq_edge_det #(.N(N)) u_edge_det (
        .clk  (clk),
        .rst  (rst),
        .irq  (irq),
        .rise (rise_s)
    );

`ifdef IRQ_LEVEL_MODE_EN
    assign lvl_s = level_sel;
`else
    assign lvl_s = {N{1'b0}};
`endif

    // Retire vector; indexes at or above N decode to nothing.
    always_comb begin
        dec_s = onehot_dec(ack_idx);
        if (ack) begin
            clr_s = dec_s[N-1:0];
        end else begin
            clr_s = {N{1'b0}};
        end
    end

    // Next pending/overflow state; a new edge beats a same-cycle ack.
    always_comb begin
        ovf_set_s     = rise_s & pending_r & ~clr_s & ~lvl_s;
        pending_nxt_s = (lvl_s & irq) | (~lvl_s & ((pending_r & ~clr_s) | rise_s));
        ovf_nxt_s     = ovf_set_s | (ovf_r & ~clr_s & ~lvl_s);
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r <= {N{1'b0}};
            mask_r    <= {N{1'b0}};
            ovf_r     <= {N{1'b0}};
        end else begin
            pending_r <= pending_nxt_s;
            ovf_r     <= ovf_nxt_s;
            if (mask_wr) begin
                mask_r <= mask_in;
            end else begin
                mask_r <= mask_r;
            end
        end
    end

    assign mask      = mask_r;
    assign pend      = pending_r & mask_r;
    assign irq_valid = |(pending_r & mask_r);
    assign overflow  = ovf_r;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Directed bench for irq_pending_latch with a per-bit behavioural model
// compared every cycle, plus literal expectations at key points.
module tb_irq_pending_latch;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] irq;
    logic [7:0] level_sel;
    logic       mask_wr;
    logic [7:0] mask_in;
    logic [7:0] mask;
    logic [7:0] pend;
    logic       irq_valid;
    logic       ack;
    logic [2:0] ack_idx;
    logic [7:0] overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    irq_pending_latch dut (
        .clk       (clk),
        .rst       (rst),
        .irq       (irq),
`ifdef IRQ_LEVEL_MODE_EN
        .level_sel (level_sel),
`endif
        .mask_wr   (mask_wr),
        .mask_in   (mask_in),
        .mask      (mask),
        .pend      (pend),
        .irq_valid (irq_valid),
        .ack       (ack),
        .ack_idx   (ack_idx),
        .overflow  (overflow)
    );

    // Behavioural model: one flag per request line, rules applied per bit.
    bit m_prev [8];
    bit m_pnd  [8];
    bit m_msk  [8];
    bit m_ovf  [8];
    bit m_ok = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            bit rose, acked, lvl;
            rose  = irq[i] && !m_prev[i];
            acked = ack && (int'(ack_idx) == i);
`ifdef IRQ_LEVEL_MODE_EN
            lvl = level_sel[i];
`else
            lvl = 1'b0;
`endif
            m_prev[i] <= irq[i];
            if (rst) begin
                m_pnd[i] <= 1'b0;
                m_msk[i] <= 1'b0;
                m_ovf[i] <= 1'b0;
            end else begin
                if (mask_wr) m_msk[i] <= mask_in[i];
                if (lvl) begin
                    m_pnd[i] <= irq[i];
                    m_ovf[i] <= 1'b0;
                end else begin
                    if (rose) m_pnd[i] <= 1'b1;
                    else if (acked) m_pnd[i] <= 1'b0;
                    if (rose && m_pnd[i] && !acked) m_ovf[i] <= 1'b1;
                    else if (acked) m_ovf[i] <= 1'b0;
                end
            end
        end
        if (rst) m_ok <= 1'b1;
    end

    // Compare process: every cycle once the model has seen a reset edge.
    always @(negedge clk) begin
        if (m_ok) begin
            logic [7:0] e_pend, e_mask, e_ovf;
            for (int i = 0; i < 8; i++) begin
                e_pend[i] = m_pnd[i] & m_msk[i];
                e_mask[i] = m_msk[i];
                e_ovf[i]  = m_ovf[i];
            end
            checks = checks + 1;
            if (pend !== e_pend || mask !== e_mask || overflow !== e_ovf ||
                irq_valid !== (e_pend != 8'h00)) begin
                errors = errors + 1;
                $display("FAIL model t=%0t pend=%h/%h mask=%h/%h ovf=%h/%h valid=%b (got/exp)",
                         $time, pend, e_pend, mask, e_mask, overflow, e_ovf, irq_valid);
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [7:0] i, input logic a, input logic [2:0] idx,
                       input logic mw, input logic [7:0] mi);
        irq = i; ack = a; ack_idx = idx; mask_wr = mw; mask_in = mi;
        step();
    endtask

    initial begin
        rst = 1'b1; irq = 8'h81; ack = 1'b0; ack_idx = 3'd0;
        mask_wr = 1'b0; mask_in = 8'h00; level_sel = 8'h00;
        step();
        step();
        chk("reset_pend", pend, 8'h00);
        chk("reset_mask", mask, 8'h00);
        chk("reset_ovf", overflow, 8'h00);
        rst = 1'b0;
        drv(8'h81, 1'b0, 3'd0, 1'b1, 8'hFF);
        chk("mask_ff", mask, 8'hFF);
        for (int k = 0; k < 5; k++) begin
            drv(8'h81, 1'b0, 3'd0, 1'b0, 8'h00);
            chk("held_through_reset", pend, 8'h00);
            chk("held_valid", {7'd0, irq_valid}, 8'h00);
        end
        drv(8'h80, 1'b0, 3'd0, 1'b0, 8'h00);
        drv(8'h81, 1'b0, 3'd0, 1'b0, 8'h00);
        chk("retrigger_bit0", pend, 8'h01);
        drv(8'h00, 1'b1, 3'd0, 1'b0, 8'h00);
        chk("ack0", pend, 8'h00);

        // two simultaneous edges retired one at a time
        drv(8'h24, 1'b0, 3'd0, 1'b0, 8'h00);
        chk("pulse_5_2", pend, 8'h24);
        drv(8'h00, 1'b1, 3'd5, 1'b0, 8'h00);
        chk("ack5", pend, 8'h04);
        drv(8'h00, 1'b1, 3'd2, 1'b0, 8'h00);
        chk("ack2", pend, 8'h00);
        chk("ack2_valid", {7'd0, irq_valid}, 8'h00);

        // masked edge is stored, exposed on unmask
        drv(8'h00, 1'b0, 3'd0, 1'b1, 8'h0F);
        chk("mask_0f", mask, 8'h0F);
        drv(8'h40, 1'b0, 3'd0, 1'b0, 8'h00);
        chk("masked_hidden", pend, 8'h00);
        drv(8'h00, 1'b0, 3'd0, 1'b1, 8'hFF);
        chk("unmask_expose", pend, 8'h40);
        drv(8'h00, 1'b1, 3'd6, 1'b0, 8'h00);
        chk("ack6", pend, 8'h00);

        // overflow on a second edge without ack
        drv(8'h08, 1'b0, 3'd0, 1'b0, 8'h00);
        drv(8'h00, 1'b0, 3'd0, 1'b0, 8'h00);
        drv(8'h08, 1'b0, 3'd0, 1'b0, 8'h00);
        chk("ovf_set", overflow, 8'h08);
        chk("ovf_pend", pend, 8'h08);
        drv(8'h00, 1'b1, 3'd3, 1'b0, 8'h00);
        chk("ovf_clr", overflow, 8'h00);
        chk("ovf_ack_pend", pend, 8'h00);

        // rise wins over same-cycle ack, no overflow
        drv(8'h02, 1'b0, 3'd0, 1'b0, 8'h00);
        drv(8'h00, 1'b0, 3'd0, 1'b0, 8'h00);
        drv(8'h02, 1'b1, 3'd1, 1'b0, 8'h00);
        chk("rise_beats_ack", pend, 8'h02);
        chk("rise_ack_ovf", overflow, 8'h00);
        drv(8'h00, 1'b1, 3'd1, 1'b0, 8'h00);
        chk("ack1", pend, 8'h00);
        drv(8'h00, 1'b1, 3'd7, 1'b0, 8'h00);
        chk("ack7_idle", pend, 8'h00);

        // held-high line does not re-trigger after ack
        drv(8'h01, 1'b0, 3'd0, 1'b0, 8'h00);
        drv(8'h01, 1'b1, 3'd0, 1'b0, 8'h00);
        drv(8'h01, 1'b0, 3'd0, 1'b0, 8'h00);
        chk("held_no_retrigger", pend, 8'h00);
        drv(8'h00, 1'b0, 3'd0, 1'b0, 8'h00);
        drv(8'h01, 1'b0, 3'd0, 1'b0, 8'h00);
        chk("low_then_high", pend, 8'h01);

        // reset mid-operation loses state, held line produces no edge
        rst = 1'b1;
        drv(8'h01, 1'b0, 3'd0, 1'b0, 8'h00);
        chk("midreset_pend", pend, 8'h00);
        chk("midreset_mask", mask, 8'h00);
        rst = 1'b0;
        drv(8'h01, 1'b0, 3'd0, 1'b1, 8'hFF);
        drv(8'h01, 1'b0, 3'd0, 1'b0, 8'h00);
        chk("post_reset_held", pend, 8'h00);
        drv(8'h00, 1'b0, 3'd0, 1'b0, 8'h00);

`ifdef IRQ_LEVEL_MODE_EN
        level_sel = 8'h10;
        for (int k = 0; k < 3; k++) begin
            drv(8'h10, 1'b1, 3'd4, 1'b0, 8'h00);
            chk("level_hold", pend, 8'h10);
            chk("level_ovf", overflow, 8'h00);
        end
        drv(8'h00, 1'b0, 3'd0, 1'b0, 8'h00);
        chk("level_drop", pend, 8'h00);
`endif

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
